// File: rtl/pipe_acc16_loader.sv
// Boot loader for the pipeAcc16 core: parses a framed, checksummed byte stream
// and writes big-endian 16-bit words into the split instruction/data memories.
module pipe_acc16_loader #(
    parameter int L_INS = 401,
    parameter int L_TOT = 1024,
    parameter int AW    = 10
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    output logic          core_rst,
    output logic          done,
    output logic          err
);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_BASE_H, S_BASE_L,
        S_DATA_H, S_DATA_L, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] LINS16 = 16'(L_INS);
    localparam logic [16:0] LTOT17 = 17'(L_TOT);

    state_t      state;
    logic [7:0]  len_h;
    logic [7:0]  base_h;
    logic [7:0]  word_h;
    logic [7:0]  sum;
    logic [15:0] rem;
    logic [15:0] uaddr;
    logic        accept;
    logic [7:0]  sum_next;
    logic [16:0] end_addr;

    function automatic logic [AW-1:0] map_addr(input logic [15:0] u);
        logic [15:0] d;
        d = (u < LINS16) ? u : (u - LINS16);
        return d[AW-1:0];
    endfunction

    assign in_ready = (state != S_DONE) && (state != S_ERR);
    assign accept   = in_valid && in_ready;
    assign sum_next = sum + in_data;
    // rem still holds the word count N while BASE_L is being accepted
    assign end_addr = {1'b0, base_h, in_data} + {1'b0, rem};

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_we    <= 1'b0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_rst  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            sum       <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (in_data == 8'hA5) begin
                            sum   <= '0;
                            state <= S_LEN_H;
                        end
                    end
                    S_LEN_H: begin
                        len_h <= in_data;
                        sum   <= sum_next;
                        state <= S_LEN_L;
                    end
                    S_LEN_L: begin
                        rem   <= {len_h, in_data};
                        sum   <= sum_next;
                        state <= S_BASE_H;
                    end
                    S_BASE_H: begin
                        base_h <= in_data;
                        sum    <= sum_next;
                        state  <= S_BASE_L;
                    end
                    S_BASE_L: begin
                        uaddr <= {base_h, in_data};
                        sum   <= sum_next;
                        if (end_addr > LTOT17) begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end else if (rem == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA_H;
                        end
                    end
                    S_DATA_H: begin
                        word_h <= in_data;
                        sum    <= sum_next;
                        state  <= S_DATA_L;
                    end
                    S_DATA_L: begin
                        mem_we    <= 1'b1;
                        mem_sel   <= (uaddr >= LINS16);
                        mem_addr  <= map_addr(uaddr);
                        mem_wdata <= {word_h, in_data};
                        uaddr     <= uaddr + 16'd1;
                        rem       <= rem - 16'd1;
                        sum       <= sum_next;
                        state     <= (rem == 16'd1) ? S_CSUM : S_DATA_H;
                    end
                    S_CSUM: begin
                        sum <= sum_next;
                        if (sum_next == 8'd0) begin
                            done     <= 1'b1;
                            core_rst <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            err   <= 1'b1;
                            state <= S_ERR;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_acc16_loader.sv
// Scoreboard bench for pipe_acc16_loader: directed frames push expected writes,
// a negedge monitor pops and compares every mem_we pulse.
module tb_pipe_acc16_loader;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic        mem_sel;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        sel;
        logic [9:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame[$];

    pipe_acc16_loader #(.L_INS(401), .L_TOT(1024), .AW(10)) dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_rst(core_rst),
        .done(done), .err(err)
    );

    always #5 clk1 = ~clk1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the head of the scoreboard
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got sel=%0d addr=%0d data=0x%0h expected none",
                         mem_sel, mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write", {5'd0, mem_sel, mem_addr, mem_wdata}, {5'd0, e.sel, e.addr, e.data});
            end
        end
    end

    task automatic push_wr(input logic sel, input logic [9:0] addr, input logic [15:0] data);
        wr_t w;
        w.sel = sel; w.addr = addr; w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gaps);
        repeat (gaps) begin
            @(negedge clk1);
            in_valid = 1'b0;
        end
        @(negedge clk1);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk1);
    endtask

    task automatic send_frame(input bit rnd);
        foreach (frame[i]) send_byte(frame[i], rnd ? int'($urandom_range(0, 3)) : 0);
        @(negedge clk1);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic check_status(input string name, input logic d, input logic e,
                                input logic cr, input logic rdy);
        @(negedge clk1);
        chk({name, "_done"}, 32'(done), 32'(d));
        chk({name, "_err"}, 32'(err), 32'(e));
        chk({name, "_core_rst"}, 32'(core_rst), 32'(cr));
        chk({name, "_in_ready"}, 32'(in_ready), 32'(rdy));
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(posedge clk1);
        @(negedge clk1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_sel", 32'(mem_sel), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk1);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // basic load
        push_wr(1'b0, 10'd0, 16'h1234);
        push_wr(1'b0, 10'd1, 16'hABCD);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(1'b0);
        check_status("basic", 1'b1, 1'b0, 1'b0, 1'b0);

        // instruction/data boundary split
        do_reset();
        push_wr(1'b0, 10'd400, 16'h1111);
        push_wr(1'b1, 10'd0, 16'h2222);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h01, 8'h90, 8'h11, 8'h11, 8'h22, 8'h22, 8'h07};
        send_frame(1'b0);
        check_status("split", 1'b1, 1'b0, 1'b0, 1'b0);

        // overflow: 0x3FF + 2 > 1024, trailing bytes must be refused
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h02, 8'h03, 8'hFF};
        send_frame(1'b0);
        check_status("ovf", 1'b0, 1'b1, 1'b1, 1'b0);
        frame = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(1'b0);
        check_status("ovf_after", 1'b0, 1'b1, 1'b1, 1'b0);

        // bad checksum
        do_reset();
        push_wr(1'b0, 10'd0, 16'h1234);
        push_wr(1'b0, 10'd1, 16'hABCD);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        send_frame(1'b0);
        check_status("badsum", 1'b0, 1'b1, 1'b1, 1'b0);

        // noise before sync plus random valid gaps
        do_reset();
        push_wr(1'b0, 10'd0, 16'h1234);
        push_wr(1'b0, 10'd1, 16'hABCD);
        frame = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34,
                  8'hAB, 8'hCD, 8'h40};
        send_frame(1'b1);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 1'b0);

        // abort a second frame after its 4th byte, rst colliding with a presented byte
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00};
        do_reset();
        send_frame(1'b0);
        @(negedge clk1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h00;
        @(negedge clk1);
        in_valid = 1'b0;
        @(negedge clk1);
        rst = 1'b0;
        check_status("abort", 1'b0, 1'b0, 1'b1, 1'b1);
        push_wr(1'b0, 10'd0, 16'h1234);
        push_wr(1'b0, 10'd1, 16'hABCD);
        frame = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_frame(1'b1);
        check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

        // empty frame
        do_reset();
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h05, 8'hFB};
        send_frame(1'b0);
        check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
